// File: rtl/int_to_fp_converter.sv
// Iterative 32-bit integer to IEEE 754 single-precision converter.
// One normalising shift per cycle, then a single round-to-nearest-even cycle.
module int_to_fp_converter #(
  parameter bit SIGNED_IN = 1'b1,
  parameter int TAG_W     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               started;
  logic [31:0]        mag;
  logic [7:0]         exp_q;
  logic               sign;
  logic               accept;
  logic               in_sign;
  logic signed [31:0] in_s;
  logic [31:0]        in_mag;

  // Returns {exponent, fraction}; a carry out of the fraction bumps the exponent.
  function automatic logic [30:0] round_rne(input logic [31:0] m, input logic [7:0] e);
    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic        up;
    logic [23:0] sum;
    logic [7:0]  e_r;
    frac   = m[30:8];
    guard  = m[7];
    sticky = |m[6:0];
    up     = guard & (sticky | frac[0]);
    sum    = {1'b0, frac} + {23'd0, up};
    e_r    = e + {7'd0, sum[23]};
    return {e_r, sum[22:0]};
  endfunction

  assign in_s      = $signed(in_data);
  assign in_sign   = SIGNED_IN & in_data[31];
  assign in_mag    = in_sign ? 32'(-in_s) : in_data;
  assign in_ready  = started & (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (in_mag == 32'd0) ? DONE : NORM;
      NORM:    if (mag[31]) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // started keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag      <= 32'd0;
      exp_q    <= 8'd0;
      sign     <= 1'b0;
      out_data <= 32'd0;
      out_tag  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          out_tag <= in_tag;
          sign    <= in_sign;
          mag     <= in_mag;
          exp_q   <= 8'd158;
          if (in_mag == 32'd0) out_data <= 32'd0;
        end
        NORM: if (!mag[31]) begin
          mag   <= mag << 1;
          exp_q <= exp_q - 8'd1;
        end
        ROUND:   out_data <= {sign, round_rne(mag, exp_q)};
        default: ;
      endcase
    end
  end

endmodule
